nsr_vec_writer: RTL and testbench
=================================

# nsr_vec_writer

Vector write sequencer placed directly upstream of the neuron state register file (NSR). Accepts one vector write request of 1, 4 or 16 32-bit words. Serialises the request into single-word writes on the NSR write port (`we`/`wa`/`wd`), one word per clock. Consecutive words go to consecutive register addresses, so a multi-word neuron-state update needs only a single-port register file.

## Interface
Parameters:
- `XLEN`, 32, word width; matches the NSR data width.
- `MAXW`, 16, maximum words per request; sets the request bus width to `XLEN*MAXW`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_vl` in 2: vector length code. `00` = 1 word, `01` = 4 words, `10` = 16 words, `11` = see Configuration.
- `req_wa` in 5: base NSR address.
- `req_wd` in `XLEN*MAXW`: payload; word i is `req_wd[XLEN*i +: XLEN]`.
- `nsr_we` out 1: NSR write enable.
- `nsr_wa` out 5: NSR write address.
- `nsr_wd` out `XLEN`: NSR write data.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse coincident with the last word's write.
- `err` out 1: one-cycle pulse on illegal VL (only when the feature is enabled).

## Operation
- Two states:
  - IDLE: `req_ready`=1, `busy`=0.
  - WRITE: `req_ready`=0, `busy`=1.
- `req_ready` is a combinational decode of state. `req_ready` never depends on `req_valid`.
- Accept = `req_valid & req_ready` at a rising edge. On accept, register:
  - the payload,
  - the base address,
  - word count N (1/4/16),
  - index i=0.
  Then go to WRITE.
- In WRITE, the registered outputs present word i each cycle:
  - `nsr_we`=1,
  - `nsr_wa` = (base + i) mod 32 (5-bit wrap),
  - `nsr_wd` = word i.
- Each edge increments i. When i = N-1, `done`=1 with that word, and the next edge returns to IDLE.
- Address wrap: base 30 with VL=`01` writes 30, 31, 0, 1.
- Payload words at index ≥ N are ignored.
- `req_*` inputs are don't-care outside the accept edge. The payload is captured, so the requester may change it right after the accept.
- Reset (asynchronous, any state, including mid-sequence):
  - state IDLE, remaining words discarded;
  - `nsr_we`=0, `nsr_wa`=0, `nsr_wd`=0, `done`=0, `err`=0, `busy`=0;
  - `req_ready`=1 while `rst_n` is low and after release.

## Timing
- Accept at edge k → words 0..N-1 presented in the cycles following edges k .. k+N-1.
- Latency: first write is visible one cycle after the accepting edge.
- Throughput: N writes per N+1 cycles. IDLE is always entered for one cycle between requests, so there is no back-to-back overlap.
- `req_ready` rises in the cycle after the last word's write.
- `nsr_we` is 0 in every IDLE cycle.
- `nsr_wa`/`nsr_wd` hold their last values when `nsr_we`=0.

## Configuration
- Macro `NSR_VL_ILLEGAL_ERR_EN`.
- Defined:
  - VL=`11` is accepted (the handshake completes) but no write is issued;
  - `err` pulses for one cycle after the accepting edge; state stays IDLE.
- Undefined:
  - VL=`11` is treated as 16 words;
  - the `err` port is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 with `req_valid`=1 → `nsr_we`=0, `busy`=0, `done`=0, `req_ready`=1, no accept.
- VL=`00`, wa=5, wd[31:0]=0xDEADBEEF:
  - one write, addr 5, data 0xDEADBEEF, `done` in the same cycle;
  - `req_ready` high 2 cycles after the accept edge.
- VL=`01`, wa=30, words 0x11,0x22,0x33,0x44 → writes (30,0x11), (31,0x22), (0,0x33), (1,0x44) on consecutive cycles; `done` on the 4th only.
- VL=`10`, wa=0, word i = i+0x100:
  - 16 consecutive writes, addr i, data i+0x100;
  - `req_valid` held high throughout → second accept only after `req_ready` returns;
  - 1 IDLE gap cycle between sequences.
- Reset pulse asserted after the 3rd word of a VL=`10` sequence:
  - outputs clear immediately, no further writes;
  - next request starts at its own word 0.
- VL=`11`:
  - with `NSR_VL_ILLEGAL_ERR_EN`: `err` 1-cycle pulse, zero writes;
  - without: 16 writes, `err`=0.

Source files
------------

// File: rtl/nsr_vec_writer.sv
// rtl/nsr_vec_writer.sv - serialises a 1/4/16-word vector write into single-word NSR writes
// Optional NSR_VL_ILLEGAL_ERR_EN: VL=11 is rejected with an err pulse instead of acting as 16 words.
module nsr_vec_writer #(
  parameter int XLEN = 32,
  parameter int MAXW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_vl,
  input  logic [4:0]           req_wa,
  input  logic [XLEN*MAXW-1:0] req_wd,
  output logic                 nsr_we,
  output logic [4:0]           nsr_wa,
  output logic [XLEN-1:0]      nsr_wd,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IW = $clog2(MAXW);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state_q, state_d;
  logic [XLEN*MAXW-1:0]  payload_q, payload_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         last_q, last_d;
  logic                  nsr_we_q, nsr_we_d;
  logic [4:0]            nsr_wa_q, nsr_wa_d;
  logic [XLEN-1:0]       nsr_wd_q, nsr_wd_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic                  req_illegal;
  logic [IW-1:0]         req_last;
  logic [IW-1:0]         idx_inc;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == WRITE);
  assign accept    = req_valid & req_ready;
  assign nsr_we    = nsr_we_q;
  assign nsr_wa    = nsr_wa_q;
  assign nsr_wd    = nsr_wd_q;
  assign done      = done_q;
  assign idx_inc   = idx_q + 1'b1;

  always_comb begin
    req_last = '0;
    case (req_vl)
      2'b00:   req_last = '0;
      2'b01:   req_last = IW'(3);
      default: req_last = IW'(MAXW - 1);
    endcase
  end

`ifdef NSR_VL_ILLEGAL_ERR_EN
  logic err_q, err_d;

  assign req_illegal = (req_vl == 2'b11);
  assign err         = err_q;

  always_comb begin
    err_d = accept & req_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign req_illegal = 1'b0;
  assign err         = 1'b0;
`endif

  // Word 0 is loaded straight from the request so it appears one cycle after accept.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    last_d    = last_q;
    nsr_we_d  = 1'b0;
    nsr_wa_d  = nsr_wa_q;
    nsr_wd_d  = nsr_wd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !req_illegal) begin
          state_d   = WRITE;
          payload_d = req_wd;
          last_d    = req_last;
          idx_d     = '0;
          nsr_we_d  = 1'b1;
          nsr_wa_d  = req_wa;
          nsr_wd_d  = req_wd[XLEN-1:0];
          done_d    = (req_last == '0);
        end
      end
      WRITE: begin
        if (done_q) begin
          state_d = IDLE;
        end else begin
          idx_d    = idx_inc;
          nsr_we_d = 1'b1;
          nsr_wa_d = nsr_wa_q + 5'd1;
          nsr_wd_d = payload_q[XLEN*int'(idx_inc) +: XLEN];
          done_d   = (idx_inc == last_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      payload_q <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      nsr_we_q  <= 1'b0;
      nsr_wa_q  <= '0;
      nsr_wd_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      nsr_we_q  <= nsr_we_d;
      nsr_wa_q  <= nsr_wa_d;
      nsr_wd_q  <= nsr_wd_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_nsr_vec_writer.sv
// tb/tb_nsr_vec_writer.sv - directed vector bench for nsr_vec_writer
module tb_nsr_vec_writer;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_vl;
  logic [4:0]   req_wa;
  logic [511:0] req_wd;
  logic         nsr_we;
  logic [4:0]   nsr_wa;
  logic [31:0]  nsr_wd;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  vl;
    logic [4:0]  wa;
    logic [31:0] base;
    logic [31:0] step;
    int          n;
  } vec_t;

  vec_t vecs[5];

  nsr_vec_writer #(.XLEN(32), .MAXW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_vl    (req_vl),
    .req_wa    (req_wa),
    .req_wd    (req_wd),
    .nsr_we    (nsr_we),
    .nsr_wa    (nsr_wa),
    .nsr_wd    (nsr_wd),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_payload(input logic [31:0] base, input logic [31:0] step, input int n);
    for (int i = 0; i < 16; i++) begin
      if (i < n) req_wd[32*i +: 32] = base + step * i;
      else       req_wd[32*i +: 32] = 32'hBAD0_0000 | i;
    end
  endtask

  task automatic run_req(input logic [1:0] vl, input logic [4:0] wa,
                         input logic [31:0] base, input logic [31:0] step, input int n);
    logic [4:0] ea;
    load_payload(base, step, n);
    req_vl    = vl;
    req_wa    = wa;
    req_valid = 1'b1;
    chk("ready_before_accept", req_ready, 1'b1);
    tick;
    req_valid = 1'b0;
    req_wd    = '1;
    req_wa    = ~wa;
    for (int i = 0; i < n; i++) begin
      ea = wa + 5'(i);
      chk("we", nsr_we, 1'b1);
      chk("wa", nsr_wa, ea);
      chk("wd", nsr_wd, base + step * i);
      chk("done", done, (i == n - 1));
      chk("busy", busy, 1'b1);
      chk("ready_low", req_ready, 1'b0);
      chk("err_low", err, 1'b0);
      tick;
    end
    chk("idle_we", nsr_we, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_ready", req_ready, 1'b1);
    chk("idle_done", done, 1'b0);
  endtask

  initial begin
    vecs[0] = '{vl: 2'b00, wa: 5'd5,  base: 32'hDEADBEEF, step: 32'h0,  n: 1};
    vecs[1] = '{vl: 2'b01, wa: 5'd30, base: 32'h11,       step: 32'h11, n: 4};
    vecs[2] = '{vl: 2'b10, wa: 5'd0,  base: 32'h100,      step: 32'h1,  n: 16};
    vecs[3] = '{vl: 2'b01, wa: 5'd7,  base: 32'hA5A50000, step: 32'h3,  n: 4};
    vecs[4] = '{vl: 2'b00, wa: 5'd31, base: 32'h12345678, step: 32'h0,  n: 1};

    // Reset held with a pending request: nothing may be accepted.
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_vl    = 2'b01;
    req_wa    = 5'd5;
    req_wd    = {16{32'hCAFEF00D}};
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_we", nsr_we, 1'b0);
    tick;
    tick;
    chk("rst_we_held", nsr_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_wa", nsr_wa, 5'd0);
    chk("rst_wd", nsr_wd, 32'd0);
    chk("rst_ready_held", req_ready, 1'b1);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    tick;

    for (int v = 0; v < 5; v++) begin
      run_req(vecs[v].vl, vecs[v].wa, vecs[v].base, vecs[v].step, vecs[v].n);
      tick;
    end

    // req_valid held high across a full sequence: one idle gap, then second accept.
    load_payload(32'h100, 32'h1, 16);
    req_vl    = 2'b10;
    req_wa    = 5'd0;
    req_valid = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) begin
      chk("b2b_we", nsr_we, 1'b1);
      chk("b2b_wa", nsr_wa, 5'(i));
      tick;
    end
    chk("gap_we", nsr_we, 1'b0);
    chk("gap_ready", req_ready, 1'b1);
    chk("gap_busy", busy, 1'b0);
    tick;
    chk("second_we", nsr_we, 1'b1);
    chk("second_wa", nsr_wa, 5'd0);
    chk("second_wd", nsr_wd, 32'h100);
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    chk("second_done", done, 1'b1);
    chk("second_last_wd", nsr_wd, 32'h10F);
    tick;
    chk("second_end_we", nsr_we, 1'b0);
    chk("second_end_ready", req_ready, 1'b1);
    tick;

    // Asynchronous reset in the middle of a 16-word sequence.
    load_payload(32'h100, 32'h1, 16);
    req_vl    = 2'b10;
    req_wa    = 5'd0;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("mid_word2_wa", nsr_wa, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", nsr_we, 1'b0);
    chk("mid_rst_wa", nsr_wa, 5'd0);
    chk("mid_rst_wd", nsr_wd, 32'd0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_no_write", nsr_we, 1'b0);
    end
    run_req(2'b01, 5'd9, 32'h700, 32'h1, 4);
    tick;

`ifdef NSR_VL_ILLEGAL_ERR_EN
    load_payload(32'h900, 32'h1, 16);
    req_vl    = 2'b11;
    req_wa    = 5'd3;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    chk("ill_err", err, 1'b1);
    chk("ill_we", nsr_we, 1'b0);
    chk("ill_busy", busy, 1'b0);
    chk("ill_ready", req_ready, 1'b1);
    tick;
    chk("ill_err_clear", err, 1'b0);
    chk("ill_we_after", nsr_we, 1'b0);
`else
    run_req(2'b11, 5'd3, 32'h900, 32'h1, 16);
`endif
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
